// File: rtl/interrupt_controller.sv
// Interrupt controller that injects a per-source instruction word into the decode stream.
// Sources are edge-detected, coalesced while pending, and granted round-robin with a gap between injections.
module interrupt_controller #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  irq_req,
  input  logic [3:0]  irq_mask,
  input  logic        stall_in,
  input  logic        jump_in,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [31:0] cfg_data,
  output logic [31:0] interrupt_instruction,
  output logic [3:0]  irq_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJECT = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);
  localparam logic       GAP_EN   = (GAP_CYCLES != 0);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  req_d_r;
  logic        primed_r;
  logic [3:0]  pending_r;
  logic [1:0]  rr_ptr_r;
  logic [1:0]  win_r;
  logic [3:0]  gap_cnt_r;
  logic [31:0] inst_r;
  logic [31:0] table_r [4];

  logic [3:0]  rise_s;
  logic [3:0]  tbl_nz_s;
  logic [3:0]  eligible_s;
  logic [3:0]  rot_s;
  logic [1:0]  off_s;
  logic [1:0]  pick_s;
  logic        pick_vld_s;
  logic        accept_s;
  logic [3:0]  clr_s;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  // The first edge after reset only captures the line levels, so a held-high line is not an edge.
  assign rise_s   = primed_r ? (irq_req & ~req_d_r) : 4'd0;
  assign accept_s = (state_r == INJECT) && !stall_in && !jump_in;
  assign clr_s    = accept_s ? onehot4(win_r) : 4'd0;

  // Eligibility: pending, unmasked and with a nonzero vector entry.
  always_comb begin
    tbl_nz_s = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tbl_nz_s[i] = |table_r[i];
    end
    eligible_s = pending_r & ~irq_mask & tbl_nz_s;
  end

  // Round-robin pick: rotate so rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot_s = 4'({eligible_s, eligible_s} >> rr_ptr_r);
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: off_s = 2'd0;
    endcase
    pick_s     = rr_ptr_r + off_s;
    pick_vld_s = |eligible_s;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_vld_s) state_nxt_s = INJECT;
        else            state_nxt_s = IDLE;
      end
      INJECT: begin
        if (accept_s) state_nxt_s = GAP_EN ? GAP : IDLE;
        else          state_nxt_s = INJECT;
      end
      GAP: begin
        if (gap_cnt_r <= 4'd1) state_nxt_s = IDLE;
        else                   state_nxt_s = GAP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    interrupt_instruction = (state_r == INJECT) ? inst_r : 32'd0;
    irq_ack               = accept_s ? onehot4(win_r) : 4'd0;
    busy                  = (state_r != IDLE);
  end

  // Request tracking, grant latch, round-robin pointer and gap counter; a new edge beats the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_d_r   <= 4'd0;
      primed_r  <= 1'b0;
      pending_r <= 4'd0;
      rr_ptr_r  <= 2'd0;
      win_r     <= 2'd0;
      gap_cnt_r <= 4'd0;
      inst_r    <= 32'd0;
    end else begin
      req_d_r   <= irq_req;
      primed_r  <= 1'b1;
      pending_r <= (pending_r & ~clr_s) | rise_s;
      if ((state_r == IDLE) && pick_vld_s) begin
        win_r  <= pick_s;
        inst_r <= table_r[pick_s];
      end else begin
        win_r  <= win_r;
        inst_r <= inst_r;
      end
      if (accept_s) begin
        rr_ptr_r  <= win_r + 2'd1;
        gap_cnt_r <= GAP_INIT;
      end else if ((state_r == GAP) && (gap_cnt_r != 4'd0)) begin
        gap_cnt_r <= gap_cnt_r - 4'd1;
      end else begin
        gap_cnt_r <= gap_cnt_r;
      end
    end
  end

  // Vector table write port.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        table_r[i] <= 32'd0;
      end
    end else if (cfg_we) begin
      table_r[cfg_idx] <= cfg_data;
    end else begin
      table_r[cfg_idx] <= table_r[cfg_idx];
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller with GAP_CYCLES = 2.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_req = 4'd0;
  logic [3:0]  irq_mask = 4'd0;
  logic        stall_in = 1'b0;
  logic        jump_in = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = 2'd0;
  logic [31:0] cfg_data = 32'd0;
  logic [31:0] interrupt_instruction;
  logic [3:0]  irq_ack;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  interrupt_controller #(.GAP_CYCLES(2)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .irq_req               (irq_req),
    .irq_mask              (irq_mask),
    .stall_in              (stall_in),
    .jump_in               (jump_in),
    .cfg_we                (cfg_we),
    .cfg_idx               (cfg_idx),
    .cfg_data              (cfg_data),
    .interrupt_instruction (interrupt_instruction),
    .irq_ack               (irq_ack),
    .busy                  (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [31:0] data);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_data = data;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic inject(input string tag, input int zeros, input logic [31:0] word, input logic [3:0] ack);
    for (int i = 0; i < zeros; i++) begin
      step();
      check({tag, "_zero"}, interrupt_instruction, 32'd0);
    end
    step();
    check({tag, "_word"}, interrupt_instruction, word);
    check({tag, "_ack"}, {28'd0, irq_ack}, {28'd0, ack});
  endtask

  task automatic idle_for(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_instr"}, interrupt_instruction, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    #2;
    check("rst_instr", interrupt_instruction, 32'd0);
    check("rst_ack", {28'd0, irq_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    cfg(2'd0, 32'h0000_0011);
    cfg(2'd1, 32'h0000_0022);
    cfg(2'd2, 32'h0840_0005);
    cfg(2'd3, 32'h0000_0033);

    // Three simultaneous requests served 0,1,3 with idle spacing between.
    irq_req = 4'b1011;
    inject("rr0", 1, 32'h0000_0011, 4'b0001);
    inject("rr1", 3, 32'h0000_0022, 4'b0010);
    inject("rr3", 3, 32'h0000_0033, 4'b1000);
    step(); step(); step();
    check("rr_done_busy", {31'd0, busy}, 32'd0);
    irq_req = 4'd0;
    step();
    // Pointer wrapped to 0: source 0 wins over source 2.
    irq_req = 4'b0101;
    inject("wrap0", 1, 32'h0000_0011, 4'b0001);
    inject("wrap2", 3, 32'h0840_0005, 4'b0100);
    irq_req = 4'd0;
    step(); step(); step();

    // Single pulse on source 2, no stall.
    irq_req = 4'b0100;
    step();
    check("basic_idle_instr", interrupt_instruction, 32'd0);
    check("basic_idle_busy", {31'd0, busy}, 32'd0);
    irq_req = 4'd0;
    step();
    check("basic_word", interrupt_instruction, 32'h0840_0005);
    check("basic_ack", {28'd0, irq_ack}, 32'h4);
    check("basic_busy", {31'd0, busy}, 32'd1);
    step();
    check("basic_gap1_instr", interrupt_instruction, 32'd0);
    check("basic_gap1_ack", {28'd0, irq_ack}, 32'd0);
    check("basic_gap1_busy", {31'd0, busy}, 32'd1);
    step();
    check("basic_gap2_instr", interrupt_instruction, 32'd0);
    check("basic_gap2_busy", {31'd0, busy}, 32'd1);
    step();
    check("basic_done_busy", {31'd0, busy}, 32'd0);

    // Stall for three cycles holds the word, ack only in the fourth.
    stall_in = 1'b1;
    irq_req  = 4'b0100;
    step();
    irq_req  = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_word", interrupt_instruction, 32'h0840_0005);
      check("stall_ack", {28'd0, irq_ack}, 32'd0);
    end
    step();
    stall_in = 1'b0;
    #1;
    check("stall_rel_word", interrupt_instruction, 32'h0840_0005);
    check("stall_rel_ack", {28'd0, irq_ack}, 32'h4);
    step();
    check("stall_gap_instr", interrupt_instruction, 32'd0);
    step(); step();
    check("stall_done_busy", {31'd0, busy}, 32'd0);

    // Jump flush, table rewrite and mask on the winner during INJECT.
    irq_req = 4'b0100;
    step();
    irq_req = 4'd0;
    step();
    jump_in  = 1'b1;
    irq_mask = 4'b0100;
    cfg_we   = 1'b1;
    cfg_idx  = 2'd2;
    cfg_data = 32'hDEAD_BEEF;
    #1;
    check("jump_word", interrupt_instruction, 32'h0840_0005);
    check("jump_ack", {28'd0, irq_ack}, 32'd0);
    step();
    jump_in = 1'b0;
    cfg_we  = 1'b0;
    #1;
    check("latched_word", interrupt_instruction, 32'h0840_0005);
    check("masked_ack", {28'd0, irq_ack}, 32'h4);
    step();
    irq_mask = 4'd0;
    check("jump_gap_instr", interrupt_instruction, 32'd0);
    step(); step();

    // Masked source stays pending and is injected once unmasked.
    irq_mask = 4'b0001;
    irq_req  = 4'b0001;
    step();
    irq_req  = 4'd0;
    idle_for("mask_hold", 3);
    irq_mask = 4'd0;
    #1;
    check("unmask_instr", interrupt_instruction, 32'd0);
    step();
    check("unmask_word", interrupt_instruction, 32'h0000_0011);
    check("unmask_ack", {28'd0, irq_ack}, 32'h1);
    step(); step(); step();

    // Zero vector entry blocks the grant until written.
    cfg(2'd1, 32'd0);
    irq_req = 4'b0010;
    step();
    irq_req = 4'd0;
    idle_for("zero_entry", 4);
    cfg(2'd1, 32'h2000_0010);
    check("zero_wr_instr", interrupt_instruction, 32'd0);
    step();
    check("zero_wr_word", interrupt_instruction, 32'h2000_0010);
    check("zero_wr_ack", {28'd0, irq_ack}, 32'h2);
    step(); step(); step();

    // Reset mid-INJECT drops the injection; a held-high line does not re-request.
    stall_in = 1'b1;
    irq_req  = 4'b1000;
    step();
    step();
    check("pre_rst_word", interrupt_instruction, 32'h0000_0033);
    #1;
    stall_in = 1'b0;
    reset    = 1'b0;
    #1;
    check("mid_rst_instr", interrupt_instruction, 32'd0);
    check("mid_rst_ack", {28'd0, irq_ack}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    step();
    reset = 1'b1;
    cfg(2'd3, 32'h0000_0033);
    idle_for("post_rst", 6);
    irq_req = 4'd0;
    step();
    irq_req = 4'b1000;
    inject("rearm", 1, 32'h0000_0033, 4'b1000);
    irq_req = 4'd0;
    step(); step(); step();
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
